// File: rtl/pulse_stretcher_if.sv
// Event-in / level-out bundle for pulse_stretcher: the time base and trigger go in,
// and the stretched level, status and overflow flag come back.
interface pulse_stretcher_if #(
    parameter int PEND_W = 2
) ();
    logic              tick;
    logic              trig;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              ovf;

    modport master (
        output tick, trig,
        input  level_out, busy, pending, ovf
    );

    modport slave (
        input  tick, trig,
        output level_out, busy, pending, ovf
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Turns single-cycle trig pulses into fixed-length level_out windows separated by a
// minimum gap, queueing pulses that arrive while a window is active.
module pulse_stretcher #(
    parameter int HIGH_TICKS = 3,
    parameter int GAP_TICKS  = 2,
    parameter int PEND_W     = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    pulse_stretcher_if.slave  ps
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_TICKS - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_TICKS - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [PEND_W-1:0] pending, pending_next;
    logic              ovf, ovf_next;
    logic              deq;
    logic              inc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pending <= pending_next;
            ovf     <= ovf_next;
        end
    end

    // A dequeue in the same cycle frees a slot, so a trig at full is still accepted.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        deq        = 1'b0;

        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                    deq        = 1'b1;
                end
            end
            HIGH: begin
                if (ps.tick) begin
                    if (cnt == HIGH_LAST) begin
                        state_next = GAP;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (ps.tick) begin
                    if (cnt == GAP_LAST) begin
                        cnt_next = '0;
                        if (pending != '0) begin
                            state_next = HIGH;
                            deq        = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        inc          = ps.trig & ((pending != PEND_MAX) | deq);
        pending_next = pending + PEND_W'(inc) - PEND_W'(deq);
        ovf_next     = ps.trig & (pending == PEND_MAX) & ~deq;
    end

    assign ps.level_out = (state == HIGH);
    assign ps.busy      = (state != IDLE) | (pending != '0);
    assign ps.pending   = pending;
    assign ps.ovf       = ovf;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a vector table for the single-window and reset
// cases, plus hand-written sequences for queueing, overflow, slow time base and refill.
module tb_pulse_stretcher;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pulse_stretcher_if #(.PEND_W(2)) bus ();

    pulse_stretcher #(
        .HIGH_TICKS(3),
        .GAP_TICKS (2),
        .PEND_W    (2),
        .CNT_W     (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .ps   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       restart;
        logic       reset_val;
        logic       tick;
        logic       trig;
        logic       exp_level;
        logic       exp_busy;
        logic [1:0] exp_pending;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rs, input logic r, input logic tg,
                                input logic l, input logic b, input logic [1:0] p, input logic o);
        vec_t v;
        v.restart     = rs;
        v.reset_val   = r;
        v.tick        = 1'b1;
        v.trig        = tg;
        v.exp_level   = l;
        v.exp_busy    = b;
        v.exp_pending = p;
        v.exp_ovf     = o;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic tk, input logic tg);
        reset    = r;
        bus.tick = tk;
        bus.trig = tg;
    endtask

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b1, 1'b0);
        step();
        step();
        reset = 1'b1;
    endtask

    function automatic logic in_win(input int c, input int s);
        return (c >= s) && (c < s + 3);
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic tv, tg, prev_level;
        int   rises, high_cycles, high_ticks, budget;

        errors = 0;
        checks = 0;
        apply_stimulus(1'b0, 1'b1, 1'b0);

        // Single window from a trig at cycle 5, then reset aborting a window at cycle 8.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        for (int c = 1; c < 5; c++) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0));
        for (int c = 7; c < 10; c++) vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0));
        for (int c = 10; c < 12; c++) vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0));
        for (int c = 12; c < 14; c++) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        for (int c = 1; c < 5; c++) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        for (int c = 10; c < 16; c++) vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].restart) do_reset();
            apply_stimulus(vecs[i].reset_val, vecs[i].tick, vecs[i].trig);
            check_output($sformatf("vec%0d level", i), 8'(bus.level_out), 8'(vecs[i].exp_level));
            check_output($sformatf("vec%0d busy", i), 8'(bus.busy), 8'(vecs[i].exp_busy));
            check_output($sformatf("vec%0d pending", i), 8'(bus.pending), 8'(vecs[i].exp_pending));
            check_output($sformatf("vec%0d ovf", i), 8'(bus.ovf), 8'(vecs[i].exp_ovf));
            step();
        end

        // Three back-to-back trigs: windows at 7, 12 and 17.
        do_reset();
        for (int c = 0; c < 25; c++) begin
            tg = (c >= 5) && (c <= 7);
            apply_stimulus(1'b1, 1'b1, tg);
            check_output($sformatf("t2 c%0d level", c), 8'(bus.level_out),
                         8'(in_win(c, 7) || in_win(c, 12) || in_win(c, 17)));
            check_output($sformatf("t2 c%0d busy", c), 8'(bus.busy), 8'((c >= 6) && (c < 22)));
            check_output($sformatf("t2 c%0d ovf", c), 8'(bus.ovf), 8'd0);
            if (c == 6 || c == 7) check_output($sformatf("t2 c%0d pending", c), 8'(bus.pending), 8'd1);
            if (c == 8) check_output("t2 c8 pending", 8'(bus.pending), 8'd2);
            step();
        end

        // Five trigs: the fifth overflows the queue and is dropped.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            tg = (c >= 5) && (c <= 9);
            apply_stimulus(1'b1, 1'b1, tg);
            check_output($sformatf("t3 c%0d level", c), 8'(bus.level_out),
                         8'(in_win(c, 7) || in_win(c, 12) || in_win(c, 17) || in_win(c, 22)));
            check_output($sformatf("t3 c%0d ovf", c), 8'(bus.ovf), 8'(c == 10));
            check_output($sformatf("t3 c%0d busy", c), 8'(bus.busy), 8'((c >= 6) && (c < 27)));
            if (c == 9 || c == 10) check_output($sformatf("t3 c%0d pending", c), 8'(bus.pending), 8'd3);
            step();
        end

        // Slow time base: tick every 4th clock, IDLE->HIGH needs no tick.
        do_reset();
        high_cycles = 0;
        high_ticks  = 0;
        for (int c = 0; c < 30; c++) begin
            tv = (c % 4 == 0);
            apply_stimulus(1'b1, tv, c == 1);
            if (bus.level_out) begin
                high_cycles++;
                if (tv) high_ticks++;
            end
            if (c == 3)  check_output("t4 c3 level", 8'(bus.level_out), 8'd1);
            if (c == 13) check_output("t4 c13 level", 8'(bus.level_out), 8'd0);
            if (c == 20) check_output("t4 c20 busy", 8'(bus.busy), 8'd1);
            if (c == 21) check_output("t4 c21 busy", 8'(bus.busy), 8'd0);
            step();
        end
        check_output("t4 high ticks", 8'(high_ticks), 8'd3);
        check_output("t4 high cycles", 8'(high_cycles), 8'd10);
        check_output("t4 final pending", 8'(bus.pending), 8'd0);

        // Full queue refilled by a trig that coincides with the GAP-end dequeue.
        do_reset();
        rises      = 0;
        prev_level = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tg = ((c >= 5) && (c <= 8)) || (c == 11);
            apply_stimulus(1'b1, 1'b1, tg);
            if (bus.level_out && !prev_level) rises++;
            prev_level = bus.level_out;
            if (c == 9)  check_output("t6 c9 pending", 8'(bus.pending), 8'd3);
            if (c == 10) check_output("t6 c10 ovf", 8'(bus.ovf), 8'd0);
            if (c == 11) begin
                check_output("t6 c11 pending", 8'(bus.pending), 8'd3);
                check_output("t6 c11 level", 8'(bus.level_out), 8'd0);
            end
            if (c == 12) begin
                check_output("t6 c12 level", 8'(bus.level_out), 8'd1);
                check_output("t6 c12 pending", 8'(bus.pending), 8'd3);
                check_output("t6 c12 ovf", 8'(bus.ovf), 8'd0);
            end
            step();
        end
        apply_stimulus(1'b1, 1'b1, 1'b0);
        budget = 0;
        while (bus.busy && budget < 80) begin
            if (bus.level_out && !prev_level) rises++;
            prev_level = bus.level_out;
            step();
            budget++;
        end
        check_output("t6 drain busy", 8'(bus.busy), 8'd0);
        check_output("t6 window count", 8'(rises), 8'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
